washing_machine_fsm: RTL and testbench

Sequencing controller for a front-loading washing machine. It interlocks the door, then steps through fill, detergent, wash, drain and rinse passes, and finishes with a spin. The controller drives valve, motor and phase indicator outputs, and reacts to level-sensitive sensor and timer inputs from the appliance plant. It sits between the sensor/timer block and the actuator drivers.

---
 rtl/washing_machine_fsm_if.sv | 27 ++
 rtl/washing_machine_fsm.sv | 109 ++++++++++
 tb/tb_washing_machine_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/washing_machine_fsm_if.sv
// Plant-side bundle for the washing machine controller: level sensors/timers in, actuators and phase flags out.
interface washing_machine_fsm_if;
   logic start;
   logic filled;
   logic doorclose;
   logic detergent;
   logic cycletime_out;
   logic drained;
   logic spintime_out;
   logic doorlock;
   logic fillvalve_on;
   logic soap_wash;
   logic motor_on;
   logic drainvalve_on;
   logic water_wash;
   logic done;

   modport master (
      output start, filled, doorclose, detergent, cycletime_out, drained, spintime_out,
      input  doorlock, fillvalve_on, soap_wash, motor_on, drainvalve_on, water_wash, done
   );

   modport slave (
      input  start, filled, doorclose, detergent, cycletime_out, drained, spintime_out,
      output doorlock, fillvalve_on, soap_wash, motor_on, drainvalve_on, water_wash, done
   );
endinterface

// File: rtl/washing_machine_fsm.sv
// Front-loader program sequencer: door interlock, soap pass, RINSE_CYCLES rinse passes, spin.
// Optional macro DOOR_ABORT_EN: opening the door in FILL/DETERGENT/WASH drains, spins and finishes.
module washing_machine_fsm #(
   parameter int unsigned RINSE_CYCLES = 1
) (
   input logic             clk,
   input logic             rst,
   washing_machine_fsm_if.slave bus
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] RINSE_MAX = CNT_W'(RINSE_CYCLES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      DETERGENT = 3'd2,
      WASH      = 3'd3,
      DRAIN     = 3'd4,
      SPIN      = 3'd5
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] rinse_cnt;
   logic             soap_q;
   logic             water_q;
   logic             done_q;
   logic             abort;

`ifdef DOOR_ABORT_EN
   assign abort = ~bus.doorclose;
`else
   assign abort = 1'b0;
`endif

   // Program sequencer; only the input belonging to the current state is looked at.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rinse_cnt <= '0;
         soap_q    <= 1'b0;
         water_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && bus.doorclose) state <= FILL;
            end
            FILL: begin
               if (abort) begin
                  state     <= DRAIN;
                  rinse_cnt <= RINSE_MAX;
               end else if (bus.filled) begin
                  state <= soap_q ? WASH : DETERGENT;
               end
            end
            DETERGENT: begin
               if (abort) begin
                  state     <= DRAIN;
                  rinse_cnt <= RINSE_MAX;
               end else if (bus.detergent) begin
                  state  <= WASH;
                  soap_q <= 1'b1;
               end
            end
            WASH: begin
               if (abort) begin
                  state     <= DRAIN;
                  rinse_cnt <= RINSE_MAX;
               end else if (bus.cycletime_out) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.drained) begin
                  if (rinse_cnt < RINSE_MAX) begin
                     state     <= FILL;
                     rinse_cnt <= rinse_cnt + CNT_W'(1);
                     water_q   <= 1'b1;
                  end else begin
                     state <= SPIN;
                  end
               end
            end
            SPIN: begin
               if (bus.spintime_out) begin
                  state     <= IDLE;
                  done_q    <= 1'b1;
                  soap_q    <= 1'b0;
                  water_q   <= 1'b0;
                  rinse_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Actuators decode from the state register, so they fall with the async reset.
   assign bus.doorlock      = (state != IDLE);
   assign bus.fillvalve_on  = (state == FILL);
   assign bus.motor_on      = (state == WASH) || (state == SPIN);
   assign bus.drainvalve_on = (state == DRAIN) || (state == SPIN);
   assign bus.soap_wash     = soap_q;
   assign bus.water_wash    = water_q;
   assign bus.done          = done_q;

endmodule

// File: tb/tb_washing_machine_fsm.sv
// Scoreboard bench for washing_machine_fsm: one instance with one rinse, one with three rinses.
module tb_washing_machine_fsm;

   // input vector: {start, doorclose, filled, detergent, cycletime_out, drained, spintime_out}
   localparam logic [6:0] I_NONE  = 7'b0000000;
   localparam logic [6:0] I_DOOR  = 7'b0100000;
   localparam logic [6:0] I_START = 7'b1100000;
   localparam logic [6:0] I_FILL  = 7'b0110000;
   localparam logic [6:0] I_DET   = 7'b0101000;
   localparam logic [6:0] I_CTO   = 7'b0100100;
   localparam logic [6:0] I_DRN   = 7'b0100010;
   localparam logic [6:0] I_SPIN  = 7'b0100001;
   localparam logic [6:0] I_SPST  = 7'b1100001;

   // output vector: {doorlock, fillvalve_on, soap_wash, motor_on, drainvalve_on, water_wash, done}
   localparam logic [6:0] E_IDLE   = 7'b0000000;
   localparam logic [6:0] E_FILL0  = 7'b1100000;
   localparam logic [6:0] E_DET    = 7'b1000000;
   localparam logic [6:0] E_WASHS  = 7'b1011000;
   localparam logic [6:0] E_DRAINS = 7'b1010100;
   localparam logic [6:0] E_FILLW  = 7'b1110010;
   localparam logic [6:0] E_WASHW  = 7'b1011010;
   localparam logic [6:0] E_DRAINW = 7'b1010110;
   localparam logic [6:0] E_SPINW  = 7'b1011110;
   localparam logic [6:0] E_DONE   = 7'b0000001;

   typedef struct packed {
      logic [6:0] iv;
      logic [6:0] ev;
   } step_t;

   logic clk;
   logic rst;
   logic start, filled, doorclose, detergent, cycletime_out, drained, spintime_out;

   int errors = 0;
   int checks = 0;
   logic [6:0] sb[$];

   washing_machine_fsm_if if1 ();
   washing_machine_fsm_if if3 ();

   assign if1.start = start;         assign if3.start = start;
   assign if1.filled = filled;       assign if3.filled = filled;
   assign if1.doorclose = doorclose; assign if3.doorclose = doorclose;
   assign if1.detergent = detergent; assign if3.detergent = detergent;
   assign if1.cycletime_out = cycletime_out; assign if3.cycletime_out = cycletime_out;
   assign if1.drained = drained;     assign if3.drained = drained;
   assign if1.spintime_out = spintime_out;   assign if3.spintime_out = spintime_out;

   washing_machine_fsm #(.RINSE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   washing_machine_fsm #(.RINSE_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [6:0] outs(input int sel);
      if (sel == 3)
         return {if3.doorlock, if3.fillvalve_on, if3.soap_wash, if3.motor_on,
                 if3.drainvalve_on, if3.water_wash, if3.done};
      return {if1.doorlock, if1.fillvalve_on, if1.soap_wash, if1.motor_on,
              if1.drainvalve_on, if1.water_wash, if1.done};
   endfunction

   task automatic set_inputs(input logic [6:0] iv);
      {start, doorclose, filled, detergent, cycletime_out, drained, spintime_out} = iv;
   endtask

   // Drive one cycle of stimulus and queue what the DUT must show after the edge.
   task automatic apply(input logic [6:0] iv, input logic [6:0] ev);
      set_inputs(iv);
      sb.push_back(ev);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_inputs(I_NONE);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic run_steps(input string name, input int sel, input step_t steps[$]);
      logic [6:0] exp_v;
      logic [6:0] got;
      for (int i = 0; i < steps.size(); i++) begin
         apply(steps[i].iv, steps[i].ev);
         exp_v = sb.pop_front();
         got   = outs(sel);
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL %s step %0d: outputs=%b expected=%b", name, i, got, exp_v);
         end
      end
   endtask

   task automatic run_prog(input string name, input int sel, input int nrinse, input bit restart);
      step_t steps[$];
      steps.push_back('{I_START, E_FILL0});
      steps.push_back('{I_FILL,  E_DET});
      steps.push_back('{I_DET,   E_WASHS});
      steps.push_back('{I_CTO,   E_DRAINS});
      for (int r = 0; r < nrinse; r++) begin
         steps.push_back('{I_DRN,  E_FILLW});
         steps.push_back('{I_FILL, E_WASHW});
         steps.push_back('{I_CTO,  E_DRAINW});
      end
      steps.push_back('{I_DRN, E_SPINW});
      if (restart) begin
         steps.push_back('{I_SPST,  E_DONE});
         steps.push_back('{I_START, E_FILL0});
         steps.push_back('{I_FILL,  E_DET});
      end else begin
         steps.push_back('{I_SPIN, E_DONE});
         steps.push_back('{I_DOOR, E_IDLE});
         steps.push_back('{I_DOOR, E_IDLE});
      end
      run_steps(name, sel, steps);
   endtask

   task automatic test_reset();
      step_t steps[$];
      logic [6:0] exp_v;
      logic [6:0] got;
      do_reset();
      steps.push_back('{I_START, E_FILL0});
      steps.push_back('{I_FILL,  E_DET});
      steps.push_back('{I_DET,   E_WASHS});
      run_steps("reset_prep", 1, steps);
      #2;
      rst = 1'b0;
      sb.push_back(E_IDLE);
      #1;
      exp_v = sb.pop_front();
      got   = outs(1);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL reset_async: outputs=%b expected=%b", got, exp_v);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      steps.delete();
      for (int i = 0; i < 4; i++) steps.push_back('{I_DOOR, E_IDLE});
      run_steps("reset_idle", 1, steps);
      run_steps("reset_idle3", 3, steps);
   endtask

   task automatic test_full_program();
      do_reset();
      run_prog("full_rc1", 1, 1, 1'b0);
   endtask

   task automatic test_gating();
      step_t steps[$];
      do_reset();
      for (int i = 0; i < 20; i++) steps.push_back('{7'b1000000, E_IDLE});
      run_steps("gating", 1, steps);
   endtask

   task automatic test_hold();
      step_t steps[$];
      do_reset();
      steps.push_back('{I_START, E_FILL0});
      for (int i = 0; i < 14; i++)
         steps.push_back('{((i % 2) == 0) ? I_DET : I_CTO, E_FILL0});
      steps.push_back('{I_FILL, E_DET});
      steps.push_back('{I_CTO,  E_DET});
      run_steps("hold", 1, steps);
   endtask

   task automatic test_rinse3();
      do_reset();
      run_prog("full_rc3", 3, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_prog("back_to_back", 1, 1, 1'b1);
   endtask

   task automatic test_door_abort();
      step_t steps[$];
      do_reset();
      steps.push_back('{I_START, E_FILL0});
      steps.push_back('{I_FILL,  E_DET});
      steps.push_back('{I_DET,   E_WASHS});
`ifdef DOOR_ABORT_EN
      steps.push_back('{I_NONE,    E_DRAINS});
      steps.push_back('{7'b0000010, 7'b1011100});
      steps.push_back('{7'b0000001, E_DONE});
      steps.push_back('{I_NONE,    E_IDLE});
`else
      steps.push_back('{I_NONE,    E_WASHS});
      steps.push_back('{I_NONE,    E_WASHS});
      steps.push_back('{7'b0000010, E_WASHS});
      steps.push_back('{I_CTO,     E_DRAINS});
`endif
      run_steps("door_abort", 1, steps);
   endtask

   initial begin
      rst = 1'b0;
      set_inputs(I_NONE);
      test_reset();
      test_full_program();
      test_gating();
      test_hold();
      test_rinse3();
      test_back_to_back();
      test_door_abort();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
